// File: rtl/mem_stage_ctrl.sv
// Purpose : word-addressed MEM-stage data memory that models multi-cycle SRAM timing.
// Latency : 1 accept cycle + WAIT_CYCLES busy cycles, then a DONE cycle with the result (WAIT_CYCLES+2 total).
// Backpr. : ready falls combinationally when a request is accepted and stays low until DONE; the pipeline freezes meanwhile.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   mem_r_en  read request from the EXE/MEM register
//   mem_w_en  write request (a write wins if both enables are high)
//   address   byte address; BASE_ADDR maps to word 0, byte-offset bits are ignored
//   wdata     store data
//   rdata     registered load result, updated only when a read completes
//   ready     0 = pipeline must freeze this cycle
//   addr_err  out-of-range flag for the DONE cycle of a bad access
//
// Optional feature: define MEM_ADDR_CHECK_EN to flag out-of-range accesses
// (index >= DEPTH or address below BASE_ADDR). Out-of-range writes are dropped
// and out-of-range reads return 0. Without it the index wraps modulo DEPTH and
// addr_err is tied to 0.

module mem_stage_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(1024),
  parameter int                DEPTH       = 64,
  parameter int                WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              addr_err
);

  // Byte-offset bits inside one word, and bits needed to index the array.
  localparam int         OFF_W    = $clog2(DATA_W / 8);
  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // WAIT_CYCLES is limited to 1..15, so a 4-bit counter always suffices.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // ---------------------------------------------------------------------
  // Address decode (combinational, from the live request)
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_full;
  logic [IDX_W-1:0]  req_idx;
  logic              req_oor;
  logic              req_vld;

  // Subtraction wraps modulo 2^ADDR_W; addresses below BASE_ADDR therefore
  // land at huge word numbers and are caught by the explicit compare below.
  assign offset    = address - BASE_ADDR;
  assign word_full = offset >> OFF_W;
  assign req_idx   = word_full[IDX_W-1:0];
  assign req_oor   = (address < BASE_ADDR) || (word_full >= ADDR_W'(DEPTH));
  assign req_vld   = mem_r_en | mem_w_en;

  // ---------------------------------------------------------------------
  // Latched request and wait counter
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [3:0]        cnt_q;

  // FSM control strobes
  logic accept;   // IDLE with a request: capture it this edge
  logic fire;     // last BUSY cycle: perform the array access this edge

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    accept    = 1'b0;
    fire      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_vld) begin
          ready     = 1'b0;
          accept    = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        ready = 1'b0;
        if (cnt_q == LAST_CNT) begin
          fire      = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // The frozen pipeline still presents the same request here; it has
        // already been served, so DONE always returns to IDLE.
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Request capture and wait counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        idx_q   <= req_idx;
        wdata_q <= wdata;
        wr_q    <= mem_w_en;     // write has priority over read
        cnt_q   <= '0;
      end else if (state == S_BUSY) begin
        cnt_q   <= cnt_q + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Storage array: never reset, contents undefined until written
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem_array [DEPTH];
  logic              mem_we;

`ifdef MEM_ADDR_CHECK_EN
  logic oor_q;
  logic addr_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oor_q <= 1'b0;
    end else if (accept) begin
      oor_q <= req_oor;
    end
  end

  assign mem_we = fire & wr_q & ~oor_q;
`else
  logic unused_oor;
  assign unused_oor = req_oor;

  assign mem_we = fire & wr_q;
`endif

  // Because fire is derived from the reset state register, a reset during
  // BUSY drops the pending write before it reaches the array.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[idx_q] <= wdata_q;
    end
  end

  // ---------------------------------------------------------------------
  // Read data: updated only on the BUSY->DONE edge of a read
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (fire && !wr_q) begin
`ifdef MEM_ADDR_CHECK_EN
      rdata <= oor_q ? '0 : mem_array[idx_q];
`else
      rdata <= mem_array[idx_q];
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Address error flag: high for the DONE cycle of an out-of-range access
  // ---------------------------------------------------------------------
`ifdef MEM_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= fire & oor_q;
    end
  end

  assign addr_err = addr_err_q;
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Purpose : self-checking bench for mem_stage_ctrl against a transaction-level memory model.
// Latency : expects ready low for WAIT_CYCLES+1 cycles per access, result in the DONE cycle.
// Backpr. : holds each request while ready is low, as a frozen pipeline would.

module tb_mem_stage_ctrl;

  localparam int WAITC = 4;
  localparam int BASE  = 1024;
  localparam int WORDS = 64;

`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] address  = '0;
  logic [31:0] wdata    = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        addr_err;

  mem_stage_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .mem_r_en (mem_r_en),
    .mem_w_en (mem_w_en),
    .address  (address),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: contents per word, whether the word is defined, and
  // the value rdata should currently hold.
  logic [31:0] mdl [WORDS];
  bit          known [WORDS];
  logic [31:0] exp_rdata = '0;
  bit          exp_valid = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void map_addr(input logic [31:0] a, output int idx, output bit oor);
    logic [31:0]     off;
    longint unsigned word;
    off  = a - 32'd1024;
    word = off / 4;
    oor  = (a < 32'd1024) || (word >= WORDS);
    idx  = int'(word % WORDS);
  endfunction

  // Called at a negedge while the DUT is idle. Returns at the negedge of the
  // DONE cycle. With hold=1 the request stays on the inputs afterwards.
  task automatic access(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
    int idx;
    bit oor;
    bit exp_err;
    int lows;
    bit done;
    map_addr(a, idx, oor);
    mem_r_en = r;
    mem_w_en = w;
    address  = a;
    wdata    = d;
    #1 check_eq("ready_on_accept", ready, 0);
    lows = 1;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (ready) begin
        done = 1;
      end else begin
        lows++;
        if (exp_valid) check_eq("rdata_hold_busy", rdata, exp_rdata);
        check_eq("addr_err_busy", addr_err, 0);
      end
    end
    check_eq("ready_done_seen", done, 1);
    check_eq("ready_low_cycles", lows, WAITC + 1);

    exp_err = CHECK_EN && oor;
    if (w) begin
      if (!exp_err) begin
        mdl[idx]   = d;
        known[idx] = 1'b1;
      end
    end else if (exp_err) begin
      exp_rdata = '0;
      exp_valid = 1'b1;
    end else begin
      exp_rdata = mdl[idx];
      exp_valid = known[idx];
    end
    if (exp_valid) check_eq("rdata_done", rdata, exp_rdata);
    check_eq("addr_err_done", addr_err, exp_err);
    if (!hold) begin
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mdl[i]   = '0;
      known[i] = 1'b0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("reset_ready", ready, 1);
    check_eq("reset_rdata", rdata, 0);
    check_eq("reset_addr_err", addr_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // Give rdata a non-zero value so the reset-clear check means something
    access(0, 1, 32'd1028, 32'h55AA55AA, 0);
    @(negedge clk);
    access(1, 0, 32'd1028, 32'h0, 0);

    // Reset mid-BUSY of a write to 1024
    @(negedge clk);
    mem_w_en = 1'b1;
    address  = 32'd1024;
    wdata    = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check_eq("ready_busy_pre_reset", ready, 0);
    #2;
    rst      = 1'b0;
    mem_w_en = 1'b0;
    #1;
    check_eq("abort_ready", ready, 1);
    check_eq("abort_rdata", rdata, 0);
    check_eq("abort_addr_err", addr_err, 0);
    exp_rdata = '0;
    exp_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(1, 0, 32'd1024, 32'h0, 0);
    check_eq("reset_write_aborted", (rdata == 32'hDEADBEEF), 0);

    // Define every word so later reads are fully predictable
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      access(0, 1, 32'(BASE + 4 * i), $urandom, 0);
    end

    // Write then read
    @(negedge clk); access(0, 1, 32'd1028, 32'h12345678, 0);
    @(negedge clk); access(1, 0, 32'd1028, 32'h0, 0);

    // Request held through DONE: next access starts only in the following cycle
    @(negedge clk); access(1, 0, 32'd1028, 32'h0, 1);
    @(negedge clk); access(1, 0, 32'd1028, 32'h0, 0);

    // Simultaneous read/write is a write
    @(negedge clk); access(1, 1, 32'd1032, 32'hA5A5A5A5, 0);
    @(negedge clk); access(1, 0, 32'd1032, 32'h0, 0);
    check_eq("rw_priority_data", rdata, 32'hA5A5A5A5);

    // Misaligned address uses the containing word
    @(negedge clk); access(0, 1, 32'd1030, 32'h0BADF00D, 0);
    @(negedge clk); access(1, 0, 32'd1028, 32'h0, 0);
    check_eq("misalign_data", rdata, 32'h0BADF00D);

    // Out of range: index 64, then read word 0 and an address below base
    @(negedge clk); access(0, 1, 32'd1280, 32'hFFFFFFFF, 0);
    @(negedge clk); access(1, 0, 32'd1024, 32'h0, 0);
    @(negedge clk); access(1, 0, 32'd1000, 32'h0, 0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int          sel;
      logic [31:0] a;
      bit          r;
      bit          w;
      bit          hold;
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = 32'(BASE) + $urandom_range(0, 255);
      else if (sel == 8) a = 32'(BASE) + $urandom_range(256, 2047);
      else               a = $urandom_range(0, 1023);
      w    = 1'($urandom_range(0, 1));
      r    = w ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      access(r, w, a, $urandom, hold);
    end

    @(negedge clk);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("final_idle_ready", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached, want finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
